// File: rtl/sramtest_pkg.sv
// Shared defaults for the sramtest characterization wrapper.
// Holds the default geometry used by the top, the SRAM model and the bus interface.
package sramtest_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 4;
  localparam int unsigned DEF_ADDR_WIDTH  = 6;
  localparam int unsigned DEF_WMASK_WIDTH = 2;

endpackage : sramtest_pkg

// File: rtl/sramtest_if.sv
// Request/response bus of the sramtest wrapper.
//   we    : 1 = write request, 0 = read request
//   wmask : per-lane write enable
//   addr  : word address
//   din   : write data
//   dout  : read data (registered inside the SRAM model)
// master = requester (drives the request), slave = sramtest.
interface sramtest_if
  import sramtest_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned WMASK_WIDTH = DEF_WMASK_WIDTH
);

  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;

  modport master (output we, output wmask, output addr, output din, input dout);
  modport slave  (input we, input wmask, input addr, input din, output dout);

endinterface : sramtest_if

// File: rtl/sramtest_mem.sv
// Behavioural single-port synchronous SRAM macro.
// Pin-compatible stand-in for a foundry macro:
//   clock   : rising-edge clock
//   reset_n : async active-low reset, clears only the output register
//   we      : 1 = masked write of din, 0 = read into dout
//   wmask   : per-lane write enable, lane width = DATA_WIDTH/WMASK_WIDTH
//   addr    : word address (full range, no wrap)
//   din     : write data
//   dout    : read data register, held during write cycles
module sramtest_mem
  import sramtest_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned WMASK_WIDTH = DEF_WMASK_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout
);

  localparam int unsigned LANE_W = DATA_WIDTH / WMASK_WIDTH;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  // Array powers up cleared; a real macro has no reset on its cells.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] dout_q;

  // Masked write: unselected lanes keep their old contents.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
        if (wmask[i]) begin
          mem_q[addr][i*LANE_W +: LANE_W] <= din[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Output register updates on reads only; writes leave it untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q <= '0;
    end else if (!we) begin
      dout_q <= mem_q[addr];
    end
  end

  assign dout = dout_q;

endmodule : sramtest_mem

// File: rtl/sramtest.sv
// Registered wrapper isolating each SRAM access to a single clock edge.
//   clock   : rising-edge clock
//   reset_n : async active-low reset; clears the request stage (forces a read of
//             address 0 with no write lanes) and the SRAM output register
//   bus     : request/response interface (slave side)
// A request is captured on edge N and performed by the SRAM on edge N+1.
module sramtest
  import sramtest_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned WMASK_WIDTH = DEF_WMASK_WIDTH
) (
  input  logic        clock,
  input  logic        reset_n,
  sramtest_if.slave   bus
);

  if ((WMASK_WIDTH == 0) || ((DATA_WIDTH % WMASK_WIDTH) != 0)) begin : g_bad_mask
    $error("sramtest: WMASK_WIDTH must divide DATA_WIDTH");
  end

  logic                   we_d,    we_q;
  logic [WMASK_WIDTH-1:0] wmask_d, wmask_q;
  logic [ADDR_WIDTH-1:0]  addr_d,  addr_q;
  logic [DATA_WIDTH-1:0]  din_d,   din_q;

  // Every cycle is an access; the stage simply samples the bus.
  always_comb begin
    we_d    = bus.we;
    wmask_d = bus.wmask;
    addr_d  = bus.addr;
    din_d   = bus.din;
  end

  // Async reset drops we_q, cancelling any captured but unperformed write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      we_q    <= we_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  sramtest_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WMASK_WIDTH (WMASK_WIDTH)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (we_q),
    .wmask   (wmask_q),
    .addr    (addr_q),
    .din     (din_q),
    .dout    (bus.dout)
  );

endmodule : sramtest

// File: tb/tb_sramtest.sv
// Self-checking bench for sramtest: directed scenarios followed by random traffic,
// compared against a word-array model that applies each request one edge after capture.
module tb_sramtest;

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 6;
  localparam int unsigned MW    = 2;
  localparam int unsigned L     = DW / MW;
  localparam int unsigned DEPTH = 1 << AW;

  logic clock;
  logic reset_n;

  sramtest_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

  sramtest #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: memory contents, expected read port, and the request
  // captured but not yet performed.
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] exp_dout;
  logic          pend_we;
  logic [MW-1:0] pend_mask;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_din;

  task automatic check(input string tag, input logic [DW-1:0] exp);
    checks++;
    assert (bus.dout === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, bus.dout, exp);
    end
  endtask

  task automatic perform_pending();
    if (pend_we) begin
      for (int i = 0; i < int'(MW); i++) begin
        if (pend_mask[i]) model_mem[pend_addr][i*L +: L] = pend_din[i*L +: L];
      end
    end else begin
      exp_dout = model_mem[pend_addr];
    end
  endtask

  // Present one request at a falling edge, let it be captured, check dout.
  task automatic step(input logic w, input logic [MW-1:0] m, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input string tag);
    bus.we    = w;
    bus.wmask = m;
    bus.addr  = a;
    bus.din   = d;
    @(posedge clock);
    perform_pending();
    pend_we   = w;
    pend_mask = m;
    pend_addr = a;
    pend_din  = d;
    @(negedge clock);
    check(tag, exp_dout);
  endtask

  // Pulse reset mid-cycle: the captured request is dropped, replaced by a read of 0.
  task automatic pulse_reset(input string tag);
    #2 reset_n = 1'b0;
    pend_we   = 1'b0;
    pend_mask = '0;
    pend_addr = '0;
    pend_din  = '0;
    exp_dout  = '0;
    #1 check({tag, "_async"}, '0);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_held"}, '0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.we    = 1'b0;
    bus.wmask = '0;
    bus.addr  = '0;
    bus.din   = '0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    exp_dout  = '0;
    pend_we   = 1'b0;
    pend_mask = '0;
    pend_addr = '0;
    pend_din  = '0;

    repeat (2) @(negedge clock);
    check("reset_dout", '0);
    reset_n = 1'b1;

    // Initial contents read as zero.
    step(1'b0, 2'b00, 6'd0,  4'h0, "init_cap0");
    step(1'b0, 2'b00, 6'd1,  4'h0, "init_rd0");
    step(1'b0, 2'b00, 6'd63, 4'h0, "init_rd1");
    step(1'b0, 2'b00, 6'd0,  4'h0, "init_rd63");
    check("init_const", 4'h0);

    // Full write and readback.
    step(1'b1, 2'b11, 6'd0, 4'hF, "full_wr_cap");
    step(1'b0, 2'b00, 6'd0, 4'h0, "full_wr_hold");
    step(1'b0, 2'b00, 6'd0, 4'h0, "full_rd");
    check("full_rd_const", 4'hF);

    // Masked write: only the low lane is written.
    step(1'b1, 2'b01, 6'd5, 4'hA, "mask_wr_cap");
    step(1'b0, 2'b00, 6'd5, 4'h0, "mask_wr_hold");
    step(1'b0, 2'b00, 6'd5, 4'h0, "mask_rd");
    check("mask_rd_const", 4'h2);

    // Top address, then address 0 untouched.
    step(1'b1, 2'b11, 6'd63, 4'h9, "top_wr_cap");
    step(1'b0, 2'b00, 6'd63, 4'h0, "top_wr_hold");
    step(1'b0, 2'b00, 6'd0,  4'h0, "top_rd63");
    check("top_rd63_const", 4'h9);
    step(1'b0, 2'b00, 6'd0,  4'h0, "top_rd0");
    check("top_rd0_const", 4'hF);

    // Reset cancels a captured write to address 3.
    step(1'b1, 2'b11, 6'd3, 4'h7, "rst_wr_cap");
    pulse_reset("rst_cancel");
    step(1'b0, 2'b00, 6'd3, 4'h0, "rst_first_rd0");
    check("rst_first_rd0_const", 4'hF);
    step(1'b0, 2'b00, 6'd3, 4'h0, "rst_rd3");
    check("rst_rd3_const", 4'h0);

    // Back-to-back write then read of the same word.
    step(1'b1, 2'b11, 6'd10, 4'h5, "b2b_wr_cap");
    step(1'b0, 2'b00, 6'd10, 4'h0, "b2b_wr_hold");
    check("b2b_hold_const", 4'h0);
    step(1'b0, 2'b00, 6'd10, 4'h0, "b2b_rd");
    check("b2b_rd_const", 4'h5);

    // Random traffic focused on a few addresses so reads hit earlier writes.
    for (int n = 0; n < 400; n++) begin
      logic          w;
      logic [MW-1:0] m;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      w = 1'($urandom_range(0, 1));
      m = MW'($urandom);
      a = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
      d = DW'($urandom);
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd_reset");
      step(w, m, a, d, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sramtest
